// File: rtl/ram_port_master.sv
// Command-driven master for a single-port RAM with a bidirectional data bus.
// Optional bursts (fill / burst read) enabled by defining RAM_PORT_MASTER_BURST_EN.
module ram_port_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [11:0] cmd_len,
    input  logic [7:0]  cmd_wdata,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        ram_wena,
    output logic [11:0] ram_addr,
    inout  wire  logic [7:0] ram_data
);
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_reg, addr_nxt;
    logic [DATA_W-1:0]   data_reg, data_nxt;
    logic                last_beat;
    logic                op_is_write;

    // Ops 01 (write) and 10 (fill) both land in WRITE; 00/11 land in READ.
    assign op_is_write = cmd_op[0] ^ cmd_op[1];

`ifdef RAM_PORT_MASTER_BURST_EN
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    assign last_beat = (cnt == '0);
`else
    logic                unused_len;
    assign unused_len = ^cmd_len;
    assign last_beat  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_reg <= '0;
            data_reg <= '0;
`ifdef RAM_PORT_MASTER_BURST_EN
            cnt      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            addr_reg <= addr_nxt;
            data_reg <= data_nxt;
`ifdef RAM_PORT_MASTER_BURST_EN
            cnt      <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_reg;
        data_nxt  = data_reg;
        cmd_ready = 1'b0;
`ifdef RAM_PORT_MASTER_BURST_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_nxt  = cmd_addr;
                    data_nxt  = cmd_wdata;
                    state_nxt = op_is_write ? WRITE : READ;
`ifdef RAM_PORT_MASTER_BURST_EN
                    cnt_nxt   = cmd_op[1] ? cmd_len : '0;
`endif
                end
            end
            WRITE, READ: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end else begin
                    // Address wraps naturally at the 12-bit boundary.
                    addr_nxt  = addr_reg + 1'b1;
`ifdef RAM_PORT_MASTER_BURST_EN
                    cnt_nxt   = cnt - 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ram_wena = (state == WRITE);
    // addr_reg only changes on accept or mid-burst, so it also holds in IDLE.
    assign ram_addr = addr_reg;
    assign ram_data = ram_wena ? data_reg : {DATA_W{1'bz}};

    // Read capture: byte returned during a READ cycle is strobed out next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (state == READ);
            if (state == READ) begin
                rd_data <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Scoreboard bench for ram_port_master with a behavioural RAM on the shared bus.
module tb_ram_port_master;
`ifdef RAM_PORT_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_addr = '0;
    logic [11:0] cmd_len = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic        ram_wena;
    logic [11:0] ram_addr;
    wire  [7:0]  ram_data;

    logic [7:0]  mem [4096];
    logic [7:0]  exp_q [$];
    logic [19:0] wr_log [$];
    int tests = 0;
    int fails = 0;

    ram_port_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Asynchronous-read RAM: drives the bus whenever the master is not writing.
    assign ram_data = ram_wena ? 8'bz : mem[ram_addr];
    always @(posedge clk) if (ram_wena) mem[ram_addr] <= ram_data;

    function automatic logic [7:0] init_val(int a);
        return 8'(a) ^ 8'h3C;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_wena) wr_log.push_back({ram_addr, ram_data});
        if (rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_strobe", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic send(input logic [1:0] op, input logic [11:0] a,
                        input logic [11:0] len, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len; cmd_wdata = d;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_fill(input logic [11:0] a, input logic [11:0] len, input logic [7:0] d);
        int nb = BURST ? int'(len) + 1 : 1;
        int cnt = 0;
        logic [11:0] ea;
        wr_log.delete();
        send(2'b10, a, len, d);
        forever begin
            @(negedge clk);
            if (!busy || cnt > 100) break;
            cnt++;
        end
        chk("fill_busy_cycles", cnt, nb);
        chk("fill_wena_cycles", wr_log.size(), nb);
        for (int i = 0; i < nb; i++) begin
            ea = a + 12'(i);
            if (i < wr_log.size()) chk("fill_bus_beat", wr_log[i], {ea, d});
            chk("fill_mem", mem[ea], d);
        end
        ea = a + 12'(nb);
        chk("fill_mem_past_end", mem[ea], init_val(int'(ea)));
    endtask

    task automatic do_burst_read(input logic [11:0] a, input logic [11:0] len, input logic [7:0] d);
        int nb = BURST ? int'(len) + 1 : 1;
        for (int i = 0; i < nb; i++) exp_q.push_back(d);
        send(2'b11, a, len, 8'h00);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("burst_read_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);

        // Reset with a command offered: must be ignored.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h055; cmd_wdata = 8'hEE;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wena", ram_wena, 0);
        chk("rst_addr", ram_addr, 12'h000);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_no_write", wr_log.size(), 0);
        chk("rst_mem_untouched", mem[12'h055], init_val(12'h055));

        // Single write then single read with latency check.
        wr_log.delete();
        send(2'b01, 12'h123, 12'h000, 8'hA5);
        wait_idle();
        chk("wr_wena_cycles", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("wr_bus", wr_log[0], {12'h123, 8'hA5});
        chk("wr_mem", mem[12'h123], 8'hA5);
        chk("addr_hold_idle", ram_addr, 12'h123);
        exp_q.push_back(8'hA5);
        send(2'b00, 12'h123, 12'h000, 8'h00);
        @(negedge clk);
        chk("rd_lat_read_cycle", rd_valid, 0);
        @(negedge clk);
        chk("rd_lat_strobe", rd_valid, 1);
        @(negedge clk);
        chk("rd_single_strobe", rd_valid, 0);
        chk("rd_data_hold", rd_data, 8'hA5);
        chk("rd_drained", exp_q.size(), 0);

        // Fill and burst read, including 12-bit address wrap.
        do_fill(12'h010, 12'd3, 8'h5A);
        do_burst_read(12'h010, 12'd3, 8'h5A);
        do_fill(12'hFFE, 12'd3, 8'h11);
        do_burst_read(12'hFFE, 12'd3, 8'h11);

        // Reset during the second beat of a long fill.
        send(2'b10, 12'h100, 12'd7, 8'hE7);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_wena", ram_wena, 0);
        chk("abort_rd_valid", rd_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_addr", ram_addr, 12'h000);
        chk("abort_first_beat", mem[12'h100], 8'hE7);
        for (int i = 2; i < 8; i++)
            chk("abort_mem_untouched", mem[12'h100 + 12'(i)], init_val(12'h100 + i));

        // Reset during a READ cycle drops the pending strobe.
        send(2'b00, 12'h123, 12'h000, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_read_no_strobe", rd_valid, 0);
        chk("abort_read_rd_data", rd_data, 8'h00);

        // Back-to-back writes with cmd_valid held high.
        begin
            int t = 0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h200; cmd_wdata = 8'h31;
            while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
            chk("b2b_first_ready", cmd_ready, 1);
            @(posedge clk); #1;
            cmd_addr = 12'h201; cmd_wdata = 8'h32;
            @(negedge clk);
            chk("b2b_ready_low_busy", cmd_ready, 0);
            chk("b2b_busy", busy, 1);
            @(negedge clk);
            chk("b2b_idle_gap_ready", cmd_ready, 1);
            chk("b2b_idle_gap_busy", busy, 0);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            wait_idle();
            chk("b2b_mem0", mem[12'h200], 8'h31);
            chk("b2b_mem1", mem[12'h201], 8'h32);
        end

        // Fill of 6 beats; collapses to a single write without bursts.
        do_fill(12'h020, 12'd5, 8'h77);
        chk("fill020_mem021", mem[12'h021], BURST ? 8'h77 : init_val(12'h021));

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
